// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the first-word-fall-through FIFO.
package fifo_pkg;

    // Sticky error flags, held until cleared or reset.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    // Occupancy counters and pointers need one bit more than the address
    // so that "full" (count == depth) is representable.
    function automatic int cnt_width(input int addr_sz);
        return addr_sz + 1;
    endfunction

endpackage

// File: rtl/fifo_fwft_prog_if.sv
// Handshake, data and status bundle between a FIFO and its user.
interface fifo_fwft_prog_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH   = 32,
    parameter int FIFO_ADDR_SZ = 4
);
    logic                                 i_wr;
    logic [FIFO_WIDTH-1:0]                i_data;
    logic                                 o_full;
    logic                                 i_rd;
    logic [FIFO_WIDTH-1:0]                o_data;
    logic                                 o_empty;
    logic [cnt_width(FIFO_ADDR_SZ)-1:0]   o_count;
    logic                                 o_almost_full;
    logic                                 o_almost_empty;
    logic                                 i_flush;
    logic                                 i_clr_err;
    logic                                 o_overflow;
    logic                                 o_underflow;

    // User side: issues requests, observes data and status.
    modport master (
        output i_wr, i_data, i_rd, i_flush, i_clr_err,
        input  o_full, o_data, o_empty, o_count, o_almost_full,
               o_almost_empty, o_overflow, o_underflow
    );

    // FIFO side.
    modport slave (
        input  i_wr, i_data, i_rd, i_flush, i_clr_err,
        output o_full, o_data, o_empty, o_count, o_almost_full,
               o_almost_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register doubles as the FIFO head register; it is not reset.
module fifo_sdp_ram #(
    parameter int WIDTH   = 32,
    parameter int ADDR_SZ = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_SZ-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [ADDR_SZ-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);
    logic [WIDTH-1:0] mem_reg [0:(1 << ADDR_SZ)-1];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem_reg[wr_addr] <= wr_data;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_reg <= mem_reg[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/fifo_fwft_prog.sv
// First-word-fall-through FIFO with programmable almost flags, flush and
// sticky overflow/underflow. The RAM read register is the head word, so
// o_data never comes combinationally from the storage array.
module fifo_fwft_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH   = 32,
    parameter int FIFO_ADDR_SZ = 4,
    parameter int AF_LEVEL     = (1 << FIFO_ADDR_SZ) - 2,
    parameter int AE_LEVEL     = 1
) (
    input logic             clk,
    input logic             reset,
    fifo_fwft_prog_if.slave bus
);
    localparam int            DEPTH   = 1 << FIFO_ADDR_SZ;
    localparam int            CW      = cnt_width(FIFO_ADDR_SZ);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            head_valid_reg, head_valid_next;
    err_flags_t      err_reg, err_next;

    logic            full;
    logic            w_wr, w_rd;
    logic            store_nonempty;
    logic            ram_wr_en, ram_rd_en;
    logic [FIFO_WIDTH-1:0] ram_rd_data;

    // Status flags come only from registered state.
    assign full           = (count_reg == DEPTH_C);
    assign w_wr           = bus.i_wr && !full;
    assign w_rd           = bus.i_rd && head_valid_reg;
    assign store_nonempty = (wr_ptr_reg != rd_ptr_reg);

    // Pointer, occupancy and head-valid next state; flush overrides requests.
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        head_valid_next = head_valid_reg;
        ram_wr_en       = 1'b0;
        ram_rd_en       = 1'b0;
        if (bus.i_flush) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            head_valid_next = 1'b0;
        end else begin
            ram_wr_en = w_wr;
            // Refill the head when it is vacant or being popped; only words
            // stored on an earlier edge are eligible, so a pop of the last
            // word with no backlog leaves a one-cycle bubble.
            ram_rd_en = (!head_valid_reg || w_rd) && store_nonempty;
            if (w_wr)      wr_ptr_next = wr_ptr_reg + ONE_C;
            if (ram_rd_en) rd_ptr_next = rd_ptr_reg + ONE_C;
            if (ram_rd_en)  head_valid_next = 1'b1;
            else if (w_rd)  head_valid_next = 1'b0;
            case ({w_wr, w_rd})
                2'b10:   count_next = count_reg + ONE_C;
                2'b01:   count_next = count_reg - ONE_C;
                default: count_next = count_reg;
            endcase
        end
    end

    // Sticky errors: clear first, so an error in the same cycle wins.
    always_comb begin
        err_next = err_reg;
        if (bus.i_clr_err) err_next = '0;
        if (bus.i_wr && full)            err_next.overflow  = 1'b1;
        if (bus.i_rd && !head_valid_reg) err_next.underflow = 1'b1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
            err_reg        <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            head_valid_reg <= head_valid_next;
            err_reg        <= err_next;
        end
    end

    fifo_sdp_ram #(
        .WIDTH   (FIFO_WIDTH),
        .ADDR_SZ (FIFO_ADDR_SZ)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_reg[FIFO_ADDR_SZ-1:0]),
        .wr_data (bus.i_data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_reg[FIFO_ADDR_SZ-1:0]),
        .rd_data (ram_rd_data)
    );

    assign bus.o_data         = ram_rd_data;
    assign bus.o_empty        = !head_valid_reg;
    assign bus.o_full         = full;
    assign bus.o_count        = count_reg;
    assign bus.o_almost_full  = (count_reg >= AF_C);
    assign bus.o_almost_empty = (count_reg <= AE_C);
    assign bus.o_overflow     = err_reg.overflow;
    assign bus.o_underflow    = err_reg.underflow;

`ifdef FORMAL
    // Occupancy bounds and consistency of count, pointers and flags.
    always @(posedge clk) begin
        if (!reset) begin
            assert (count_reg <= DEPTH_C);
            assert (count_reg == (wr_ptr_reg - rd_ptr_reg) + CW'(head_valid_reg));
            assert (full == (count_reg == DEPTH_C));
            assert (!(full && !head_valid_reg));
        end
    end

    // Two arbitrary consecutive words must leave in the order they entered.
    (* anyconst *) logic [31:0]           f_idx;
    (* anyconst *) logic [FIFO_WIDTH-1:0] f_a;
    (* anyconst *) logic [FIFO_WIDTH-1:0] f_b;
    logic [31:0] f_wr_cnt, f_rd_cnt;
    logic        f_live;

    // Count accepted transfers since reset; a flush ends the tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_wr_cnt <= '0;
            f_rd_cnt <= '0;
            f_live   <= 1'b1;
        end else if (bus.i_flush) begin
            f_live <= 1'b0;
        end else begin
            if (w_wr) f_wr_cnt <= f_wr_cnt + 32'd1;
            if (w_rd) f_rd_cnt <= f_rd_cnt + 32'd1;
        end
    end

    // Inject the tracked words and check them on the way out.
    always_comb begin
        if (!reset && f_live && !bus.i_flush) begin
            if (w_wr && f_wr_cnt == f_idx)         assume (bus.i_data == f_a);
            if (w_wr && f_wr_cnt == f_idx + 32'd1) assume (bus.i_data == f_b);
            if (w_rd && f_rd_cnt == f_idx)         assert (bus.o_data == f_a);
            if (w_rd && f_rd_cnt == f_idx + 32'd1) assert (bus.o_data == f_b);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_fwft_prog.sv
// Directed and randomized bench for fifo_fwft_prog against a queue model.
module tb_fifo_fwft_prog;
    localparam int W     = 8;
    localparam int A     = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 2;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    initial forever #5 clk = ~clk;

    fifo_fwft_prog_if #(.FIFO_WIDTH(W), .FIFO_ADDR_SZ(A)) bus();

    fifo_fwft_prog #(
        .FIFO_WIDTH   (W),
        .FIFO_ADDR_SZ (A),
        .AF_LEVEL     (AF),
        .AE_LEVEL     (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: every held word in order, plus whether the head is
    // presented. The head is refilled only from words stored before the edge.
    logic [W-1:0] mq[$];
    bit           m_hv  = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = mq.size();
        chk({ctx, ":empty"},  32'(bus.o_empty),        32'(!m_hv));
        chk({ctx, ":count"},  32'(bus.o_count),        32'(n));
        chk({ctx, ":full"},   32'(bus.o_full),         32'(n == DEPTH));
        chk({ctx, ":afull"},  32'(bus.o_almost_full),  32'(n >= AF));
        chk({ctx, ":aempty"}, 32'(bus.o_almost_empty), 32'(n <= AE));
        chk({ctx, ":ovf"},    32'(bus.o_overflow),     32'(m_ovf));
        chk({ctx, ":unf"},    32'(bus.o_underflow),    32'(m_unf));
        if (m_hv) chk({ctx, ":data"}, 32'(bus.o_data), 32'(mq[0]));
    endtask

    // One clock cycle: drive requests, let the edge pass, update model, check.
    task automatic cycle(input bit wr, input bit rd, input logic [W-1:0] d,
                         input bit fl, input bit clr, input string ctx);
        bit full_pre, w_wr, w_rd;
        int stored_pre;
        logic [W-1:0] dropped;
        bus.i_wr = wr; bus.i_rd = rd; bus.i_data = d;
        bus.i_flush = fl; bus.i_clr_err = clr;
        full_pre = (mq.size() == DEPTH);
        w_wr = wr && !full_pre;
        w_rd = rd && m_hv;
        @(posedge clk);
        #1;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (wr && full_pre) m_ovf = 1'b1;
        if (rd && !m_hv)    m_unf = 1'b1;
        if (fl) begin
            mq.delete();
            m_hv = 1'b0;
        end else begin
            stored_pre = mq.size() - (m_hv ? 1 : 0);
            if (w_rd) dropped = mq.pop_front();
            m_hv = (m_hv && !w_rd) || (stored_pre > 0);
            if (w_wr) mq.push_back(d);
        end
        txn++;
        $display("txn %0d %s wr=%0b rd=%0b din=%0h fl=%0b clr=%0b -> cnt=%0d empty=%0b dout=%0h ovf=%0b unf=%0b",
                 txn, ctx, wr, rd, d, fl, clr, bus.o_count, bus.o_empty, bus.o_data,
                 bus.o_overflow, bus.o_underflow);
        check_all(ctx);
    endtask

    initial begin
        bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_data = '0;
        bus.i_flush = 1'b0; bus.i_clr_err = 1'b0;

        // Reset state while reset is held.
        @(posedge clk);
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(0, 0, 8'h00, 0, 0, "idle");

        // Single write: visible one edge after acceptance.
        cycle(1, 0, 8'hA5, 0, 0, "a5_wr");
        cycle(0, 0, 8'h00, 0, 0, "a5_vis");
        chk("a5_data", 32'(bus.o_data), 32'h0000_00A5);
        chk("a5_count", 32'(bus.o_count), 32'd1);
        cycle(0, 1, 8'h00, 0, 0, "a5_pop");

        // Fill to full, overflow, drain in order.
        for (int i = 1; i <= 4; i++) cycle(1, 0, 8'(i), 0, 0, "fill");
        chk("fill_full", 32'(bus.o_full), 32'd1);
        cycle(1, 0, 8'h05, 0, 0, "over");
        chk("over_flag", 32'(bus.o_overflow), 32'd1);
        chk("over_count", 32'(bus.o_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("order", 32'(bus.o_data), 32'(i));
            cycle(0, 1, 8'h00, 0, 0, "drain");
        end
        cycle(0, 0, 8'h00, 0, 1, "clr_ovf");

        // Underflow and clear precedence.
        cycle(0, 1, 8'h00, 0, 0, "under");
        chk("under_flag", 32'(bus.o_underflow), 32'd1);
        cycle(0, 0, 8'h00, 0, 1, "clr_unf");
        cycle(0, 1, 8'h00, 0, 0, "under2");
        cycle(0, 1, 8'h00, 0, 1, "clr_vs_err");
        chk("clr_loses", 32'(bus.o_underflow), 32'd1);
        cycle(0, 0, 8'h00, 0, 1, "clr_unf2");

        // Streaming across pointer wrap with a constant count.
        cycle(1, 0, 8'd1, 0, 0, "pre1");
        cycle(1, 0, 8'd2, 0, 0, "pre2");
        cycle(0, 0, 8'd0, 0, 0, "pre_idle");
        for (int i = 0; i < 3 * DEPTH; i++) begin
            chk("wrap_data", 32'(bus.o_data), 32'(i + 1));
            cycle(1, 1, 8'(i + 3), 0, 0, "stream");
            chk("wrap_count", 32'(bus.o_count), 32'd2);
        end
        cycle(0, 1, 8'd0, 0, 0, "post1");
        cycle(0, 1, 8'd0, 0, 0, "post2");

        // Flush has priority over a write in the same cycle.
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'(8'h40 + i), 0, 0, "fl_fill");
        cycle(1, 0, 8'h77, 1, 0, "flush");
        chk("flush_count", 32'(bus.o_count), 32'd0);
        chk("flush_empty", 32'(bus.o_empty), 32'd1);
        cycle(1, 0, 8'h88, 0, 0, "fl_wr");
        cycle(0, 0, 8'h00, 0, 0, "fl_vis");
        chk("flush_drop", 32'(bus.o_data), 32'h0000_0088);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5), 8'($urandom),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0), "rand");
        end

        // Asynchronous reset in the middle of a burst.
        cycle(0, 0, 8'h00, 1, 1, "ar_prep");
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h90 + i), 0, 0, "ar_fill");
        cycle(1, 1, 8'h99, 0, 0, "ar_burst");
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        m_hv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all("async_rst");
        bus.i_wr = 1'b0; bus.i_rd = 1'b0;
        #2;
        reset = 1'b0;
        cycle(0, 0, 8'h00, 0, 0, "ar_idle");
        cycle(1, 0, 8'h3C, 0, 0, "ar_wr");
        cycle(0, 0, 8'h00, 0, 0, "ar_vis");
        chk("ar_resume", 32'(bus.o_data), 32'h0000_003C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_fwft_prog.md
FIFO_FWFT_PROG -- requirements
Module: fifo_fwft_prog

Interface
REQ-001 Parameter FIFO_WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter FIFO_ADDR_SZ, default 4, log2 of depth; FIFO_DEPTH = 2^FIFO_ADDR_SZ words (FIFO_ADDR_SZ >= 1).
REQ-003 Parameter AF_LEVEL, default FIFO_DEPTH-2, almost-full threshold in words (1..FIFO_DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost-empty threshold in words (0..FIFO_DEPTH-1).
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port i_wr, input, 1, write request.
REQ-008 Port i_data, input, FIFO_WIDTH, write data.
REQ-009 Port o_full, output, 1, no space for a write.
REQ-010 Port i_rd, input, 1, read/pop request of the word currently on o_data.
REQ-011 Port o_data, output, FIFO_WIDTH, registered head word (first-word-fall-through).
REQ-012 Port o_empty, output, 1, o_data not valid.
REQ-013 Port o_count, output, FIFO_ADDR_SZ+1, words held including the output register.
REQ-014 Port o_almost_full, o_almost_empty, output, 1 each, threshold flags.
REQ-015 Port i_flush, input, 1, synchronous discard of all contents.
REQ-016 Port i_clr_err, input, 1, synchronous clear of sticky error flags.
REQ-017 Port o_overflow, o_underflow, output, 1 each, sticky error flags.

Function
REQ-018 Accepted write w_wr = i_wr && !o_full; accepted read w_rd = i_rd && !o_empty; rejected requests change no storage, pointer or count.
REQ-019 o_data SHALL be driven from a register (head register), never combinationally from storage.
REQ-020 Head register loads from storage whenever it is empty or popped (w_rd) and storage holds a word; storage read is synchronous (registered RAM).
REQ-021 Latency: word accepted into empty FIFO at edge k -> o_empty low and o_data = that word after edge k+1.
REQ-022 o_count: +1 after edge with w_wr only, -1 with w_rd only, unchanged with both or neither; counts words in storage plus head register.
REQ-023 o_full = (o_count == FIFO_DEPTH); o_empty = !head_valid; both derived from registered state, no combinational path from i_wr/i_rd.
REQ-024 o_almost_full = (o_count >= AF_LEVEL); o_almost_empty = (o_count <= AE_LEVEL).
REQ-025 Pointers are FIFO_ADDR_SZ+1 bits, wrap modulo 2*FIFO_DEPTH; storage indexed by low FIFO_ADDR_SZ bits; ordering preserved across wrap.
REQ-026 Simultaneous w_wr and w_rd when full: read accepted, write rejected (o_full high that cycle); overflow set.
REQ-027 Simultaneous w_wr and w_rd when one word held: head advances to new word with one-cycle bubble permitted only if storage empty (o_empty high for one cycle), count stays 1 then settles correctly.
REQ-028 i_wr while o_full sets o_overflow after that edge; i_rd while o_empty sets o_underflow; flags hold until i_clr_err or reset.
REQ-029 i_flush has priority over i_wr/i_rd the same cycle: after the edge pointers = 0, o_count = 0, o_empty = 1; flags unaffected.
REQ-030 i_clr_err clears both flags after the edge; an error event in the same cycle wins (flag stays set).

Reset
REQ-031 reset asserted asynchronously forces: pointers 0, head invalid, o_count 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0, o_overflow 0, o_underflow 0; o_data value undefined.
REQ-032 Reset mid-operation discards all words; storage array itself is not reset.
REQ-033 Reset deassertion takes effect on next rising edge; no accepted operation in the deassertion cycle is required.

Structure
REQ-034 Shared package fifo_pkg holds count/pointer width helper function and error-flag struct type.
REQ-035 Storage SHALL be sub-module fifo_sdp_ram (simple dual-port, sync write, registered read), FIFO_WIDTH x FIFO_DEPTH.
REQ-036 Formal properties (count <= FIFO_DEPTH, flag consistency, order preservation of two anyconst words) under ifdef FORMAL.

Verification
REQ-037 Reset, write 0xA5 once, no read -> o_empty low after next edge, o_data = 0xA5, o_count = 1.
REQ-038 ADDR_SZ=2: write 1,2,3,4 -> o_full=1, o_almost_full=1 at count 2; 5th write -> o_overflow=1, count stays 4; read 4 -> 1,2,3,4 in order.
REQ-039 Read on empty -> o_underflow=1; i_clr_err -> 0 next edge; i_clr_err with concurrent bad read -> stays 1.
REQ-040 Continuous write+read every cycle for 3*FIFO_DEPTH words -> incrementing data out in order across pointer wrap, count constant.
REQ-041 Fill to 3 words, assert i_flush with i_wr -> o_count=0, o_empty=1 next edge, written word dropped.
REQ-042 Assert reset asynchronously mid-burst between edges -> all outputs at reset values immediately, before next clk edge.
